// File: rtl/enc_binder_bank.sv
// -----------------------------------------------------------------------------
// enc_binder_bank
//
// Purpose:
//   Binds NUM_CH level hypervectors by circular rotation. Channel i is rotated
//   by s_i = shift_entry(SHIFT_BASE + i) mod HV_DIM, where shift_entry() is the
//   encoder shift table. Results are committed LANES channels per cycle under
//   a start/busy/done handshake. A run takes G = ceil(NUM_CH/LANES) cycles.
//   Sits between the level-HV lookup and the bundling stage.
//
// Ports:
//   clk            in   system clock, all state on the rising edge
//   nrst           in   asynchronous active-low reset
//   start_encoding in   run request, sampled only while busy is low
//   unbind         in   (ENC_BINDER_BANK_UNBIND_EN only) rotate right instead of left
//   level_hv       in   NUM_CH x HV_DIM level hypervectors, captured on an accepted start
//   busy           out  high while a bind run is in progress
//   done           out  one-cycle pulse when the last group has been written
//   shifted_hv     out  NUM_CH x HV_DIM registered bound hypervectors
//
// Optional feature macro:
//   ENC_BINDER_BANK_UNBIND_EN - adds the unbind input (inverse rotation).
// -----------------------------------------------------------------------------
module enc_binder_bank #(
  parameter int HV_DIM     = 1024,
  parameter int NUM_CH     = 10,
  parameter int LANES      = 5,
  parameter int SHIFT_BASE = 260
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic                           start_encoding,
`ifdef ENC_BINDER_BANK_UNBIND_EN
  input  logic                           unbind,
`endif
  input  logic [NUM_CH-1:0][HV_DIM-1:0]  level_hv,
  output logic                           busy,
  output logic                           done,
  output logic [NUM_CH-1:0][HV_DIM-1:0]  shifted_hv
);

  localparam int NUM_GRP = (NUM_CH + LANES - 1) / LANES;
  localparam int GRP_W   = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NUM_GRP - 1);

  // Encoder shift table. Entries may exceed HV_DIM; they are reduced modulo
  // HV_DIM at elaboration.
  function automatic int shift_entry(input int idx);
    return (idx * 613 + 97) % 4093;
  endfunction

  typedef enum logic {IDLE, BIND} state_t;

  state_t                          state_q, state_d;
  logic [GRP_W-1:0]                grp_q, grp_d;
  logic [NUM_CH-1:0][HV_DIM-1:0]   cap_q, cap_d;
  logic [NUM_CH-1:0][HV_DIM-1:0]   shifted_q, shifted_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;
  logic [HV_DIM-1:0]               rot_hv [NUM_CH];
`ifdef ENC_BINDER_BANK_UNBIND_EN
  logic                            unbind_q, unbind_d;
`endif

  // Each channel's shift is an elaboration constant, so its rotator is pure
  // wiring. The LANES-wide time multiplexing is realised by the per-group
  // write enables below rather than by muxing inputs into shared shifters.
  // Shifting by HV_DIM yields zero, so s_i = 0 degenerates to pass-through.
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_rot
    localparam int SH = shift_entry(SHIFT_BASE + ch) % HV_DIM;
`ifdef ENC_BINDER_BANK_UNBIND_EN
    assign rot_hv[ch] = unbind_q
                      ? ((cap_q[ch] >> SH) | (cap_q[ch] << (HV_DIM - SH)))
                      : ((cap_q[ch] << SH) | (cap_q[ch] >> (HV_DIM - SH)));
`else
    assign rot_hv[ch] = (cap_q[ch] << SH) | (cap_q[ch] >> (HV_DIM - SH));
`endif
  end

  // State register: FSM, group counter, capture and output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      grp_q     <= '0;
      cap_q     <= '0;
      shifted_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef ENC_BINDER_BANK_UNBIND_EN
      unbind_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grp_q     <= grp_d;
      cap_q     <= cap_d;
      shifted_q <= shifted_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef ENC_BINDER_BANK_UNBIND_EN
      unbind_q  <= unbind_d;
`endif
    end
  end

  // Next-state: one BIND cycle per group, then back to IDLE.
  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    case (state_q)
      IDLE: begin
        if (start_encoding) begin
          state_d = BIND;
          grp_d   = '0;
        end
      end
      BIND: begin
        if (grp_q == LAST_GRP) begin
          state_d = IDLE;
          grp_d   = '0;
        end else begin
          grp_d = grp_q + GRP_W'(1);
        end
      end
    endcase
  end

  // Datapath/outputs: capture on an accepted start, commit one group per
  // BIND cycle. Channels outside the current group keep their old values.
  always_comb begin
    cap_d     = cap_q;
    shifted_d = shifted_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef ENC_BINDER_BANK_UNBIND_EN
    unbind_d  = unbind_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_encoding) begin
          cap_d  = level_hv;
          busy_d = 1'b1;
`ifdef ENC_BINDER_BANK_UNBIND_EN
          unbind_d = unbind;
`endif
        end
      end
      BIND: begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
          if (GRP_W'(ch / LANES) == grp_q) begin
            shifted_d[ch] = rot_hv[ch];
          end
        end
        if (grp_q == LAST_GRP) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
    endcase
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign shifted_hv = shifted_q;

endmodule

// File: tb/tb_enc_binder_bank.sv
// -----------------------------------------------------------------------------
// tb_enc_binder_bank
//
// Self-checking bench for enc_binder_bank. Three instances share clock and
// reset: dut_a (10 ch, 5 lanes, G=2), dut_b (10 ch, 3 lanes, G=4) and
// dut_c (7 ch, 3 lanes, G=3, partial last group). Expected outputs come from
// a bit-level rotation model driven by the shift table rule.
// -----------------------------------------------------------------------------
module tb_enc_binder_bank;

  localparam int D = 1024;

  logic clk = 1'b0;
  logic nrst;

  logic             start_a, busy_a, done_a;
  logic [9:0][D-1:0] lv_a, sh_a;
  logic             start_b, busy_b, done_b;
  logic [9:0][D-1:0] lv_b, sh_b;
  logic             start_c, busy_c, done_c;
  logic [6:0][D-1:0] lv_c, sh_c;
`ifdef ENC_BINDER_BANK_UNBIND_EN
  logic unbind_a, unbind_b, unbind_c;
`endif

  logic [D-1:0] exp_a [10];
  logic [D-1:0] exp_b [10];
  logic [D-1:0] exp_c [7];

  int vectors;
  int miscompares;

  enc_binder_bank #(.HV_DIM(D), .NUM_CH(10), .LANES(5), .SHIFT_BASE(260)) dut_a (
    .clk(clk), .nrst(nrst), .start_encoding(start_a),
`ifdef ENC_BINDER_BANK_UNBIND_EN
    .unbind(unbind_a),
`endif
    .level_hv(lv_a), .busy(busy_a), .done(done_a), .shifted_hv(sh_a));

  enc_binder_bank #(.HV_DIM(D), .NUM_CH(10), .LANES(3), .SHIFT_BASE(260)) dut_b (
    .clk(clk), .nrst(nrst), .start_encoding(start_b),
`ifdef ENC_BINDER_BANK_UNBIND_EN
    .unbind(unbind_b),
`endif
    .level_hv(lv_b), .busy(busy_b), .done(done_b), .shifted_hv(sh_b));

  enc_binder_bank #(.HV_DIM(D), .NUM_CH(7), .LANES(3), .SHIFT_BASE(260)) dut_c (
    .clk(clk), .nrst(nrst), .start_encoding(start_c),
`ifdef ENC_BINDER_BANK_UNBIND_EN
    .unbind(unbind_c),
`endif
    .level_hv(lv_c), .busy(busy_c), .done(done_c), .shifted_hv(sh_c));

  always #5 clk = ~clk;

  // Shift table entry for channel ch (base 260), reduced modulo D.
  function automatic int shift_of(input int ch);
    return ((260 + ch) * 613 + 97) % 4093 % D;
  endfunction

  // Reference rotation, bit by bit: left means out[(j+s)%D] = in[j].
  function automatic logic [D-1:0] rot_model(input logic [D-1:0] v, input int s, input bit right);
    logic [D-1:0] r;
    r = '0;
    for (int j = 0; j < D; j++) begin
      if (!right) r[(j + s) % D] = v[j];
      else        r[j] = v[(j + s) % D];
    end
    return r;
  endfunction

  function automatic logic [D-1:0] rand_hv();
    logic [D-1:0] r;
    for (int w = 0; w < D / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    start_a = 1'b1; start_b = 1'b1; start_c = 1'b1;
    for (int ch = 0; ch < 10; ch++) begin lv_a[ch] = rand_hv(); lv_b[ch] = rand_hv(); end
    for (int ch = 0; ch < 7; ch++) lv_c[ch] = rand_hv();
    for (int ch = 0; ch < 10; ch++) begin exp_a[ch] = '0; exp_b[ch] = '0; end
    for (int ch = 0; ch < 7; ch++) exp_c[ch] = '0;
    tick();
    for (int pass = 0; pass < 2; pass++) begin
      vectors++;
      if (sh_a !== '0 || sh_b !== '0 || sh_c !== '0) begin
        miscompares++;
        $display("[TB] FAIL reset_hv pass%0d a[63:0]=%h b[63:0]=%h c[63:0]=%h required 0",
                 pass, sh_a[0][63:0], sh_b[0][63:0], sh_c[0][63:0]);
      end
      vectors++;
      if ({busy_a, busy_b, busy_c, done_a, done_b, done_c} !== 6'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_flags pass%0d busy=%b%b%b done=%b%b%b required all 0",
                 pass, busy_a, busy_b, busy_c, done_a, done_b, done_c);
      end
      if (pass == 0) begin
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        repeat (5) tick();
      end
    end
  endtask

  task automatic test_onehot_bind();
    logic [D-1:0] src [10];
    for (int ch = 0; ch < 10; ch++) begin
      src[ch] = '0;
      src[ch][ch] = 1'b1;
      lv_a[ch] = src[ch];
    end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    vectors++;
    if (busy_a !== 1'b1 || done_a !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL onehot_accept busy=%b done=%b required busy=1 done=0", busy_a, done_a);
    end
    for (int g = 0; g < 2; g++) begin
      tick();
      for (int ch = 0; ch < 10; ch++)
        if (ch / 5 == g) exp_a[ch] = rot_model(src[ch], shift_of(ch), 1'b0);
      for (int ch = 0; ch < 10; ch++) begin
        vectors++;
        if (sh_a[ch] !== exp_a[ch]) begin
          miscompares++;
          $display("[TB] FAIL onehot_g%0d ch%0d got[63:0]=%h required[63:0]=%h diffbits=%0d",
                   g, ch, sh_a[ch][63:0], exp_a[ch][63:0], $countones(sh_a[ch] ^ exp_a[ch]));
        end
      end
      vectors++;
      if (done_a !== (g == 1) || busy_a !== (g == 0)) begin
        miscompares++;
        $display("[TB] FAIL onehot_flags_g%0d done=%b busy=%b required done=%b busy=%b",
                 g, done_a, busy_a, g == 1, g == 0);
      end
    end
    tick();
    vectors++;
    if (done_a !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL onehot_done_pulse done=%b required 0", done_a);
    end
  endtask

  task automatic test_random_bind();
    logic [D-1:0] src [10];
    for (int run = 0; run < 3; run++) begin
      for (int ch = 0; ch < 10; ch++) begin src[ch] = rand_hv(); lv_a[ch] = src[ch]; end
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      // Scribble the inputs; the captured copy must be used.
      for (int ch = 0; ch < 10; ch++) lv_a[ch] = rand_hv();
      for (int g = 0; g < 2; g++) begin
        tick();
        for (int ch = 0; ch < 10; ch++)
          if (ch / 5 == g) exp_a[ch] = rot_model(src[ch], shift_of(ch), 1'b0);
        for (int ch = 0; ch < 10; ch++) begin
          vectors++;
          if (sh_a[ch] !== exp_a[ch]) begin
            miscompares++;
            $display("[TB] FAIL random_r%0d_g%0d ch%0d got[63:0]=%h required[63:0]=%h diffbits=%0d",
                     run, g, ch, sh_a[ch][63:0], exp_a[ch][63:0], $countones(sh_a[ch] ^ exp_a[ch]));
          end
        end
        vectors++;
        if (done_a !== (g == 1)) begin
          miscompares++;
          $display("[TB] FAIL random_done_r%0d_g%0d done=%b required %b", run, g, done_a, g == 1);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [D-1:0] src1 [10];
    logic [D-1:0] src2 [10];
    for (int ch = 0; ch < 10; ch++) begin src1[ch] = rand_hv(); src2[ch] = rand_hv(); lv_a[ch] = src1[ch]; end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    for (int ch = 0; ch < 10; ch++) exp_a[ch] = rot_model(src1[ch], shift_of(ch), 1'b0);
    vectors++;
    if (done_a !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_first_done done=%b required 1", done_a);
    end
    // Request the next run during the done cycle.
    for (int ch = 0; ch < 10; ch++) lv_a[ch] = src2[ch];
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    vectors++;
    if (done_a !== 1'b0 || busy_a !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_accept done=%b busy=%b required done=0 busy=1", done_a, busy_a);
    end
    tick();
    tick();
    for (int ch = 0; ch < 10; ch++) exp_a[ch] = rot_model(src2[ch], shift_of(ch), 1'b0);
    vectors++;
    if (done_a !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_second_done done=%b required 1", done_a);
    end
    for (int ch = 0; ch < 10; ch++) begin
      vectors++;
      if (sh_a[ch] !== exp_a[ch]) begin
        miscompares++;
        $display("[TB] FAIL b2b_data ch%0d got[63:0]=%h required[63:0]=%h diffbits=%0d",
                 ch, sh_a[ch][63:0], exp_a[ch][63:0], $countones(sh_a[ch] ^ exp_a[ch]));
      end
    end
    tick();
  endtask

  task automatic test_ignored_start();
    logic [D-1:0] src1 [10];
    logic [D-1:0] src2 [10];
    for (int ch = 0; ch < 10; ch++) begin src1[ch] = rand_hv(); src2[ch] = rand_hv(); lv_b[ch] = src1[ch]; end
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    repeat (4) tick();
    for (int ch = 0; ch < 10; ch++) exp_b[ch] = rot_model(src1[ch], shift_of(ch), 1'b0);
    vectors++;
    if (done_b !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ign_first_done done=%b required 1", done_b);
    end
    tick();
    // Second run; hold start high through T+1 with different data.
    for (int ch = 0; ch < 10; ch++) lv_b[ch] = src2[ch];
    start_b = 1'b1;
    tick();
    for (int ch = 0; ch < 10; ch++) lv_b[ch] = rand_hv();
    for (int cyc = 1; cyc <= 6; cyc++) begin
      tick();
      if (cyc == 1) start_b = 1'b0;
      for (int ch = 0; ch < 10; ch++)
        if (ch / 3 == cyc - 1) exp_b[ch] = rot_model(src2[ch], shift_of(ch), 1'b0);
      for (int ch = 0; ch < 10; ch++) begin
        vectors++;
        if (sh_b[ch] !== exp_b[ch]) begin
          miscompares++;
          $display("[TB] FAIL ign_retain_t%0d ch%0d got[63:0]=%h required[63:0]=%h diffbits=%0d",
                   cyc, ch, sh_b[ch][63:0], exp_b[ch][63:0], $countones(sh_b[ch] ^ exp_b[ch]));
        end
      end
      vectors++;
      if (done_b !== (cyc == 4)) begin
        miscompares++;
        $display("[TB] FAIL ign_done_t%0d done=%b required %b", cyc, done_b, cyc == 4);
      end
    end
  endtask

  task automatic test_partial_group();
    logic [D-1:0] src [7];
    lv_c = '1;
    for (int ch = 0; ch < 7; ch++) src[ch] = '1;
    for (int run = 0; run < 2; run++) begin
      start_c = 1'b1;
      tick();
      start_c = 1'b0;
      for (int cyc = 1; cyc <= 4; cyc++) begin
        tick();
        for (int ch = 0; ch < 7; ch++)
          if (ch / 3 == cyc - 1) exp_c[ch] = rot_model(src[ch], shift_of(ch), 1'b0);
        for (int ch = 0; ch < 7; ch++) begin
          vectors++;
          if (sh_c[ch] !== exp_c[ch]) begin
            miscompares++;
            $display("[TB] FAIL partial_r%0d_t%0d ch%0d got[63:0]=%h required[63:0]=%h diffbits=%0d",
                     run, cyc, ch, sh_c[ch][63:0], exp_c[ch][63:0], $countones(sh_c[ch] ^ exp_c[ch]));
          end
        end
        vectors++;
        if (done_c !== (cyc == 3)) begin
          miscompares++;
          $display("[TB] FAIL partial_done_r%0d_t%0d done=%b required %b", run, cyc, done_c, cyc == 3);
        end
      end
      // Second run uses random data to exercise the real rotations.
      for (int ch = 0; ch < 7; ch++) begin src[ch] = rand_hv(); lv_c[ch] = src[ch]; end
    end
  endtask

  task automatic test_abort();
    for (int ch = 0; ch < 10; ch++) lv_a[ch] = rand_hv();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    @(negedge clk);
    nrst = 1'b0;
    #1;
    vectors++;
    if (sh_a !== '0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_clear sh[63:0]=%h busy=%b done=%b required all 0",
               sh_a[0][63:0], busy_a, done_a);
    end
    for (int ch = 0; ch < 10; ch++) begin exp_a[ch] = '0; exp_b[ch] = '0; end
    for (int ch = 0; ch < 7; ch++) exp_c[ch] = '0;
    @(negedge clk);
    nrst = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      tick();
      vectors++;
      if (done_a !== 1'b0 || busy_a !== 1'b0 || sh_a !== '0) begin
        miscompares++;
        $display("[TB] FAIL abort_quiet_t%0d done=%b busy=%b sh[63:0]=%h required 0",
                 cyc, done_a, busy_a, sh_a[0][63:0]);
      end
    end
  endtask

`ifdef ENC_BINDER_BANK_UNBIND_EN
  task automatic test_unbind();
    logic [D-1:0] src [10];
    for (int ch = 0; ch < 10; ch++) begin src[ch] = rand_hv(); lv_a[ch] = src[ch]; end
    unbind_a = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    for (int ch = 0; ch < 10; ch++) begin
      vectors++;
      if (sh_a[ch] !== rot_model(src[ch], shift_of(ch), 1'b0)) begin
        miscompares++;
        $display("[TB] FAIL unbind_fwd ch%0d got[63:0]=%h", ch, sh_a[ch][63:0]);
      end
    end
    lv_a = sh_a;
    unbind_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    unbind_a = 1'b0;
    tick();
    tick();
    vectors++;
    if (done_a !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL unbind_done done=%b required 1", done_a);
    end
    for (int ch = 0; ch < 10; ch++) begin
      vectors++;
      if (sh_a[ch] !== src[ch]) begin
        miscompares++;
        $display("[TB] FAIL unbind_inverse ch%0d got[63:0]=%h required[63:0]=%h diffbits=%0d",
                 ch, sh_a[ch][63:0], src[ch][63:0], $countones(sh_a[ch] ^ src[ch]));
      end
    end
    tick();
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    nrst = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    lv_a = '0; lv_b = '0; lv_c = '0;
`ifdef ENC_BINDER_BANK_UNBIND_EN
    unbind_a = 1'b0; unbind_b = 1'b0; unbind_c = 1'b0;
`endif
    test_reset();
    test_onehot_bind();
    test_random_bind();
    test_back_to_back();
    test_ignored_start();
    test_partial_group();
    test_abort();
`ifdef ENC_BINDER_BANK_UNBIND_EN
    test_unbind();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
